qr_sched: RTL and testbench
===========================

QR_SCHED -- requirements
Module: qr_sched

Interface
REQ-001 SHALL have parameter SAMPLES_PER_MAT, default 20, meaning 48-bit samples per channel matrix.
REQ-002 SHALL have parameter MATS_PER_FRAME, default 10, meaning results per frame before o_last_data.
REQ-003 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_trig  input  1  one input sample valid this cycle.
REQ-006 SHALL have port i_core_done  input  2  per-core QRD-finish pulse, bit k = core k.
REQ-007 SHALL have port o_load_en  output  2  per-core sample-write enable, one-hot or zero.
REQ-008 SHALL have port o_buf_cnt  output  5  sample index 0..SAMPLES_PER_MAT-1 within the current matrix.
REQ-009 SHALL have port o_start  output  2  per-core one-cycle compute-start pulse.
REQ-010 SHALL have port o_out_sel  output  1  core whose y_hat/R drive the top-level outputs.
REQ-011 SHALL have port o_rd_vld  output  1  one-cycle result-valid strobe.
REQ-012 SHALL have port o_last_data  output  1  high with the final o_rd_vld of a frame.
REQ-013 SHALL have port o_err  output  1  sticky overrun flag.

Function
REQ-014 SHALL keep a per-core FSM with states EMPTY, LOADING, BUSY, HELD.
REQ-015 SHALL keep load pointer load_sel; target core = load_sel.
- EMPTY->LOADING on the first accepted sample.
- LOADING->BUSY on sample SAMPLES_PER_MAT-1.
- BUSY->HELD on i_core_done[k].
- HELD->EMPTY on the cycle o_rd_vld is asserted for core k.
REQ-016 SHALL accept a sample when i_trig=1 and target core is EMPTY or LOADING.
- On accept, o_load_en[load_sel]=1 combinationally in the same cycle.
- On accept, o_buf_cnt advances next cycle, wrapping SAMPLES_PER_MAT-1 -> 0.
REQ-017 SHALL toggle load_sel when sample SAMPLES_PER_MAT-1 is accepted.
REQ-018 SHALL, when the matrix's last sample is accepted, pulse o_start[k] high for exactly the following cycle.
REQ-019 SHALL drop a sample if i_trig=1 and the target core is BUSY or HELD.
- o_load_en=0 and o_buf_cnt unchanged.
- o_err set (see REQ-027).
REQ-020 SHALL emit results strictly in load order, using o_out_sel as the next-to-read pointer.
REQ-021 SHALL assert registered o_rd_vld for one cycle when core o_out_sel is HELD, then toggle o_out_sel on the next edge.
- Latency: i_core_done[k] at cycle n -> o_rd_vld at cycle n+1 when k = o_out_sel.
REQ-022 SHALL hold a core that finishes while not selected in HELD until its turn.
- If both done bits are high in the same cycle: o_rd_vld on n+1 and n+2, selected core first.
REQ-023 SHALL ignore i_core_done[k] unless core k is BUSY.
REQ-024 SHALL count o_rd_vld strobes with a counter 0..MATS_PER_FRAME-1.
- o_last_data asserts coincident with the strobe at count MATS_PER_FRAME-1.
- The counter then wraps to 0.
REQ-025 SHALL permit loading one core while the other is BUSY or HELD, with no bubble at the matrix boundary.

Reset
REQ-026 SHALL, on i_rst_n low, asynchronously apply these values, including mid-load or mid-compute:
- Both FSMs EMPTY, load_sel=0, o_buf_cnt=0, o_out_sel=0, frame counter 0.
- o_load_en=0, o_start=0, o_rd_vld=0, o_last_data=0, o_err=0.
- Partial matrices are discarded.

Configuration
REQ-027 SHALL, with macro QR_SCHED_ERR_EN defined:
- Set o_err on any dropped sample.
- Hold o_err until reset.
REQ-028 SHALL, with QR_SCHED_ERR_EN undefined:
- Tie o_err to 0.
- Still drop samples as in REQ-019.

Verification
REQ-029 SHALL cover: 20 back-to-back i_trig, done[0] pulse 5 cycles later -> o_load_en=01 for all 20 cycles; o_start=01 at cycle 21; o_rd_vld at done+1; o_out_sel 0->1.
REQ-030 SHALL cover: 40 continuous samples -> o_load_en=01 for samples 0-19 and 10 for samples 20-39; o_buf_cnt wraps 19->0 at sample 20; o_start pulses 01 then 10.
REQ-031 SHALL cover: done[1] three cycles before done[0] with o_out_sel=0 -> o_rd_vld for core 0 first, then for core 1 on the next cycle.
REQ-032 SHALL cover: 60 samples with both cores BUSY -> samples 41-60 dropped; o_err=1 with QR_SCHED_ERR_EN defined, o_err=0 without.
REQ-033 SHALL cover: 10 matrices processed -> o_last_data=1 only with the 10th o_rd_vld; the 11th result shows o_last_data=0.
REQ-034 SHALL cover: i_rst_n pulsed low at sample 7 -> all outputs return to the REQ-026 values immediately; the next load starts at core 0 with o_buf_cnt=0.

Source files
------------

// File: rtl/qr_sched.sv
// qr_sched: ping-pong scheduler for two QRD cores (load, start, in-order result readout)
// Optional feature macro: QR_SCHED_ERR_EN (sticky overrun flag; o_err tied to 0 otherwise)
// Ports:
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_trig       input sample valid this cycle
//   i_core_done  per-core QRD finish pulse (bit k = core k)
//   o_load_en    per-core sample-write enable (one-hot or zero, combinational)
//   o_buf_cnt    sample index within the matrix being loaded
//   o_start      per-core one-cycle compute-start pulse
//   o_out_sel    core whose results drive the outputs (next-to-read pointer)
//   o_rd_vld     one-cycle result-valid strobe
//   o_last_data  high with the final o_rd_vld of a frame
//   o_err        sticky overrun flag
module qr_sched #(
    parameter int SAMPLES_PER_MAT = 20,
    parameter int MATS_PER_FRAME  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_trig,
    input  logic [1:0] i_core_done,
    output logic [1:0] o_load_en,
    output logic [4:0] o_buf_cnt,
    output logic [1:0] o_start,
    output logic       o_out_sel,
    output logic       o_rd_vld,
    output logic       o_last_data,
    output logic       o_err
);
    localparam int FW = (MATS_PER_FRAME > 1) ? $clog2(MATS_PER_FRAME) : 1;
    typedef enum logic [1:0] {EMPTY, LOADING, BUSY, HELD} st_t;
    st_t           r_st [2];
    st_t           w_st_nxt [2];
    logic          r_load_sel;
    logic          r_out_sel;
    logic          r_rd_vld;
    logic [4:0]    r_buf_cnt;
    logic [1:0]    r_start;
    logic [FW-1:0] r_frm;
    logic          w_acc;
    logic          w_last_smp;
    logic          w_nsel;
    // Gated by reset so the combinational enable stays low while reset is held.
    assign w_acc      = i_rst_n && i_trig && (r_st[r_load_sel] == EMPTY || r_st[r_load_sel] == LOADING);
    assign w_last_smp = w_acc && r_buf_cnt == 5'(SAMPLES_PER_MAT - 1);
    // Core that will be selected after this edge: the pointer moves past a core as it is read.
    assign w_nsel     = r_rd_vld ? ~r_out_sel : r_out_sel;
    assign o_load_en   = w_acc ? (r_load_sel ? 2'b10 : 2'b01) : 2'b00;
    assign o_buf_cnt   = r_buf_cnt;
    assign o_start     = r_start;
    assign o_out_sel   = r_out_sel;
    assign o_rd_vld    = r_rd_vld;
    assign o_last_data = r_rd_vld && r_frm == FW'(MATS_PER_FRAME - 1);
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_st_nxt[k] = r_st[k];
            case (r_st[k])
                EMPTY, LOADING: if (w_acc && r_load_sel == 1'(k)) w_st_nxt[k] = w_last_smp ? BUSY : LOADING;
                BUSY:           if (i_core_done[k]) w_st_nxt[k] = HELD;
                HELD:           if (r_rd_vld && r_out_sel == 1'(k)) w_st_nxt[k] = EMPTY;
                default:        w_st_nxt[k] = r_st[k];
            endcase
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_st[0]    <= EMPTY;
            r_st[1]    <= EMPTY;
            r_load_sel <= 1'b0;
            r_out_sel  <= 1'b0;
            r_rd_vld   <= 1'b0;
            r_buf_cnt  <= 5'd0;
            r_start    <= 2'b00;
            r_frm      <= '0;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
            if (w_acc) r_buf_cnt <= w_last_smp ? 5'd0 : r_buf_cnt + 5'd1;
            if (w_last_smp) r_load_sel <= ~r_load_sel;
            r_start <= w_last_smp ? (r_load_sel ? 2'b10 : 2'b01) : 2'b00;
            // Looking at the next state lets a done pulse produce the strobe one cycle later.
            r_rd_vld <= w_st_nxt[w_nsel] == HELD;
            if (r_rd_vld) begin
                r_out_sel <= ~r_out_sel;
                r_frm     <= (r_frm == FW'(MATS_PER_FRAME - 1)) ? '0 : r_frm + 1'b1;
            end
        end
    end
`ifdef QR_SCHED_ERR_EN
    logic r_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_err <= 1'b0;
        else if (i_trig && !w_acc) r_err <= 1'b1;
    end
    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_qr_sched.sv
// tb_qr_sched: self-checking bench for qr_sched with a result scoreboard
module tb_qr_sched;
    localparam int SPM = 20;
    localparam int MPF = 10;
`ifdef QR_SCHED_ERR_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       trig = 1'b0;
    logic [1:0] done = 2'b00;
    logic [1:0] o_load_en, o_start;
    logic [4:0] o_buf_cnt;
    logic       o_out_sel, o_rd_vld, o_last_data, o_err;
    int         checks = 0;
    int         failures = 0;
    logic [1:0] exp_q [$];
    logic [1:0] pend_start = 2'b00;
    logic [1:0] e;
    int         tb_frm = 0;

    qr_sched #(.SAMPLES_PER_MAT(SPM), .MATS_PER_FRAME(MPF)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_trig(trig), .i_core_done(done),
        .o_load_en(o_load_en), .o_buf_cnt(o_buf_cnt), .o_start(o_start),
        .o_out_sel(o_out_sel), .o_rd_vld(o_rd_vld), .o_last_data(o_last_data), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: each strobe must match the oldest completed matrix {core, last}.
    always @(negedge clk) begin
        if (rst_n && o_rd_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_empty: o_rd_vld=1 required 0 (no result pending)");
            end else begin
                e = exp_q.pop_front();
                if ({o_out_sel, o_last_data} !== e) begin
                    failures++;
                    $display("FAIL sb_result: out_sel,last=%b required %b", {o_out_sel, o_last_data}, e);
                end
            end
        end
    end

    task automatic cyc(input logic t, input logic [1:0] d);
        @(posedge clk);
        #1;
        trig = t;
        done = d;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        trig = 1'b0;
        done = 2'b00;
        exp_q.delete();
        tb_frm = 0;
        pend_start = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic load_mat(input logic core);
        logic [1:0] oh;
        oh = core ? 2'b10 : 2'b01;
        for (int i = 0; i < SPM; i++) begin
            cyc(1'b1, 2'b00);
            checks++;
            if (o_load_en !== oh || o_buf_cnt !== 5'(i)) begin
                failures++;
                $display("FAIL load core%0d smp%0d: load_en=%b buf_cnt=%0d required load_en=%b buf_cnt=%0d",
                         core, i, o_load_en, o_buf_cnt, oh, i);
            end
            if (i == 0) begin
                checks++;
                if (o_start !== pend_start) begin
                    failures++;
                    $display("FAIL start_at_boundary: o_start=%b required %b", o_start, pend_start);
                end
            end
        end
        exp_q.push_back({core, tb_frm == MPF - 1});
        tb_frm = (tb_frm == MPF - 1) ? 0 : tb_frm + 1;
        pend_start = oh;
    endtask

    task automatic check_start();
        cyc(1'b0, 2'b00);
        checks++;
        if (o_start !== pend_start) begin
            failures++;
            $display("FAIL start_pulse: o_start=%b required %b", o_start, pend_start);
        end
        pend_start = 2'b00;
    endtask

    task automatic finish_core(input logic k);
        cyc(1'b0, k ? 2'b10 : 2'b01);
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL rd_vld_early core%0d: o_rd_vld=%b required 0", k, o_rd_vld);
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b1 || o_out_sel !== k) begin
            failures++;
            $display("FAIL rd_vld_latency core%0d: rd_vld=%b out_sel=%b required 1 %b", k, o_rd_vld, o_out_sel, k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_hold: outputs=%b required 0", {o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 2'b00);
        checks++;
        if ({o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_release: outputs=%b required 0", {o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err});
        end
    endtask

    task automatic test_single();
        apply_reset();
        load_mat(1'b0);
        check_start();
        cyc(1'b0, 2'b00);
        checks++;
        if (o_start !== 2'b00) begin
            failures++;
            $display("FAIL start_one_cycle: o_start=%b required 00", o_start);
        end
        repeat (2) cyc(1'b0, 2'b00);
        finish_core(1'b0);
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b0 || o_out_sel !== 1'b1) begin
            failures++;
            $display("FAIL out_sel_toggle: rd_vld=%b out_sel=%b required 0 1", o_rd_vld, o_out_sel);
        end
        cyc(1'b0, 2'b01);
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL done_ignored: o_rd_vld=%b required 0", o_rd_vld);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        load_mat(1'b0);
        load_mat(1'b1);
        check_start();
        finish_core(1'b0);
        finish_core(1'b1);
    endtask

    task automatic test_out_of_order();
        apply_reset();
        load_mat(1'b0);
        load_mat(1'b1);
        check_start();
        cyc(1'b0, 2'b10);
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL held_not_selected: o_rd_vld=%b required 0", o_rd_vld);
        end
        cyc(1'b0, 2'b00);
        cyc(1'b0, 2'b01);
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b1 || o_out_sel !== 1'b0) begin
            failures++;
            $display("FAIL ooo_first: rd_vld=%b out_sel=%b required 1 0", o_rd_vld, o_out_sel);
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b1 || o_out_sel !== 1'b1) begin
            failures++;
            $display("FAIL ooo_second: rd_vld=%b out_sel=%b required 1 1", o_rd_vld, o_out_sel);
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b0 || o_out_sel !== 1'b0) begin
            failures++;
            $display("FAIL ooo_after: rd_vld=%b out_sel=%b required 0 0", o_rd_vld, o_out_sel);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        load_mat(1'b0);
        load_mat(1'b1);
        for (int i = 0; i < SPM; i++) begin
            cyc(1'b1, 2'b00);
            checks++;
            if (o_load_en !== 2'b00 || o_buf_cnt !== 5'd0) begin
                failures++;
                $display("FAIL drop smp%0d: load_en=%b buf_cnt=%0d required 00 0", i + 40, o_load_en, o_buf_cnt);
            end
            if (i == 0) begin
                checks++;
                if (o_start !== pend_start || o_err !== 1'b0) begin
                    failures++;
                    $display("FAIL drop_first: start=%b err=%b required %b 0", o_start, o_err, pend_start);
                end
            end
        end
        pend_start = 2'b00;
        cyc(1'b0, 2'b00);
        checks++;
        if (o_err !== EXP_ERR) begin
            failures++;
            $display("FAIL err_flag: o_err=%b required %b", o_err, EXP_ERR);
        end
        cyc(1'b0, 2'b11);
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b1 || o_out_sel !== 1'b0) begin
            failures++;
            $display("FAIL both_done_first: rd_vld=%b out_sel=%b required 1 0", o_rd_vld, o_out_sel);
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b1 || o_out_sel !== 1'b1) begin
            failures++;
            $display("FAIL both_done_second: rd_vld=%b out_sel=%b required 1 1", o_rd_vld, o_out_sel);
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (o_rd_vld !== 1'b0 || o_err !== EXP_ERR) begin
            failures++;
            $display("FAIL both_done_after: rd_vld=%b err=%b required 0 %b", o_rd_vld, o_err, EXP_ERR);
        end
    endtask

    task automatic test_frame();
        apply_reset();
        for (int m = 0; m <= MPF; m++) begin
            load_mat(m % 2 == 1);
            check_start();
            finish_core(m % 2 == 1);
            checks++;
            if (o_last_data !== (m == MPF - 1)) begin
                failures++;
                $display("FAIL last_data mat%0d: o_last_data=%b required %b", m, o_last_data, m == MPF - 1);
            end
        end
        cyc(1'b0, 2'b00);
        checks++;
        if (exp_q.size() != 0 || o_rd_vld !== 1'b0) begin
            failures++;
            $display("FAIL frame_drain: pending=%0d rd_vld=%b required 0 0", exp_q.size(), o_rd_vld);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        load_mat(1'b0);
        check_start();
        for (int i = 0; i < 7; i++) cyc(1'b1, 2'b00);
        checks++;
        if (o_load_en !== 2'b10 || o_buf_cnt !== 5'd6) begin
            failures++;
            $display("FAIL pre_reset_load: load_en=%b buf_cnt=%0d required 10 6", o_load_en, o_buf_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        tb_frm = 0;
        pend_start = 2'b00;
        #1;
        checks++;
        if ({o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_async: outputs=%b required 0", {o_load_en, o_buf_cnt, o_start, o_out_sel, o_rd_vld, o_last_data, o_err});
        end
        repeat (2) @(posedge clk);
        #1;
        trig = 1'b0;
        rst_n = 1'b1;
        load_mat(1'b0);
        check_start();
        finish_core(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_order();
        test_overrun();
        test_frame();
        test_reset_mid();
        cyc(1'b0, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
